c1_fetch: RTL

Parametrised instruction-fetch front end for the C1 core: owns the program counter, issues word addresses to a fixed-latency instruction ROM, and delivers instructions downstream over a valid/ready handshake. Generalises the free-running single-cycle `pc + 1` counter with configurable PC, address and instruction widths, configurable ROM latency, back-pressure through a skid FIFO, and branch redirect with squash of in-flight fetches. Sits between the instruction ROM and the decoder/ALU pipeline.

---
 rtl/c1_fetch.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/c1_fetch.sv
// -----------------------------------------------------------------------------
// c1_fetch -- instruction-fetch front end for the C1 core.
//
// Owns the program counter, issues word addresses to a fixed-latency
// instruction ROM and hands instructions to the decoder over a valid/ready
// handshake. A small skid FIFO absorbs every read already in flight when the
// consumer stalls. A branch redirect reloads the PC and squashes everything
// in flight or buffered.
//
// Parameters
//   PC_W      program counter width (word addressed)
//   ADDR_W    ROM address width, ADDR_W <= PC_W
//   INSN_W    instruction width
//   ROM_LAT   ROM read latency in cycles, 1..4
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk             clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   rom_en          ROM read strobe for rom_addr this cycle
//   rom_addr        low ADDR_W bits of pc
//   rom_data        ROM word, valid ROM_LAT cycles after rom_en
//   redirect_valid  load redirect_pc and squash all fetches in flight
//   redirect_pc     redirect target
//   insn_valid      an instruction is at the FIFO head
//   insn_ready      consumer accepts the head this cycle
//   insn            instruction at the FIFO head (0 when empty)
//   insn_pc         PC of the head instruction (0 when empty)
//   pc              next PC to be issued
//
// Optional build macro
//   C1_FETCH_PERF_EN  adds perf_fetched / perf_squashed, two 32-bit
//                     saturating counters of issued reads and of entries
//                     discarded by redirects. Absent when undefined.
// -----------------------------------------------------------------------------
module c1_fetch #(
  parameter int              PC_W     = 64,
  parameter int              ADDR_W   = 8,
  parameter int              INSN_W   = 32,
  parameter int              ROM_LAT  = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INSN_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  output logic [PC_W-1:0]   pc
`ifdef C1_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed
`endif
);

  // FIFO depth: one slot per read that can be in flight plus the head.
  localparam int DEPTH = ROM_LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Occupancy sums in-flight reads and FIFO entries, so one extra bit.
  localparam int OCC_W = CNT_W + 1;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]    r_pc;

  // Shadow pipeline: stage i holds the read issued i+1 cycles ago.
  logic [ROM_LAT-1:0] r_sh_vld;
  logic [PC_W-1:0]    r_sh_pc [ROM_LAT];

  // Output FIFO, circular buffer.
  logic [INSN_W-1:0]  r_fifo_insn [DEPTH];
  logic [PC_W-1:0]    r_fifo_pc   [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [OCC_W-1:0]   w_outstanding;
  logic [OCC_W-1:0]   w_occ;
  logic               w_pop;
  logic               w_ret;
  logic               w_issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Occupancy and issue decision
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so the running sum below is
  // read back within the same evaluation; clocked blocks use '<=' only.
  // NOTE: every variable an always_comb block writes gets a default first, so
  // no path leaves it holding a stale value and no latch is inferred.
  always_comb begin
    w_outstanding = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      w_outstanding = w_outstanding + OCC_W'(r_sh_vld[i]);
    end
  end

  assign insn_valid = (r_count != '0);
  assign w_pop      = insn_valid && insn_ready;

  // The read at the last shadow stage is counted once here: it leaves the
  // shadow pipeline and enters the FIFO at the same edge.
  assign w_occ   = w_outstanding + OCC_W'(r_count) - OCC_W'(w_pop);
  assign w_issue = !rst && !redirect_valid && (w_occ < DEPTH_OCC);

  // ROM data for the oldest shadow entry is on rom_data this cycle.
  assign w_ret   = r_sh_vld[ROM_LAT-1];

  assign rom_en   = w_issue;
  assign rom_addr = r_pc[ADDR_W-1:0];
  assign pc       = r_pc;

  // ---------------------------------------------------------------------------
  // Program counter: reset beats redirect beats issue. Wraps modulo 2^PC_W.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is updated with non-blocking '<=' so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_issue) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow pipeline
  // ---------------------------------------------------------------------------
  // Valid bits are cleared by reset and by redirect, which squashes every
  // read still in flight.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_sh_vld <= '0;
    end else begin
      r_sh_vld[0] <= w_issue;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_sh_vld[i] <= r_sh_vld[i-1];
      end
    end
  end

  // NOTE: payload storage (shadow PCs, FIFO words) carries no reset; the
  // valid bits and FIFO count decide whether it is ever looked at.
  always_ff @(posedge clk) begin
    r_sh_pc[0] <= r_pc;
    for (int i = 1; i < ROM_LAT; i++) begin
      r_sh_pc[i] <= r_sh_pc[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      // A pop or a return coinciding with redirect is dropped with the rest.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_ret) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_ret) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ret) begin
      r_fifo_insn[r_wr_ptr] <= rom_data;
      r_fifo_pc[r_wr_ptr]   <= r_sh_pc[ROM_LAT-1];
    end
  end

  // Head is forced to zero when empty so the idle and reset value is clean.
  assign insn    = insn_valid ? r_fifo_insn[r_rd_ptr] : '0;
  assign insn_pc = insn_valid ? r_fifo_pc[r_rd_ptr]   : '0;

  // Issue is throttled on occupancy, so a return can never find the FIFO
  // full without a pop in the same cycle.
  a_fifo_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_ret && !w_pop && !redirect_valid && (r_count == FULL_CNT)));

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef C1_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;
  logic [32:0] w_squash_sum;

  // Squashed entries are every live shadow read (including one returning
  // this cycle) plus everything in the FIFO; a coincident pop is discarded.
  assign w_squash_sum = {1'b0, r_perf_squashed} + 33'(w_outstanding) + 33'(r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (w_issue && (r_perf_fetched != '1)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        r_perf_squashed <= w_squash_sum[32] ? '1 : w_squash_sum[31:0];
      end
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`else
  // Counters compiled out; the fetch path is identical either way.
`endif

endmodule
